// File: rtl/seq_divider.sv
// Signed restoring divider: one quotient bit per clock, MIPS-style quotient on lo and remainder on hi.
// Zero divisor short-circuits to a flagged ready pulse and leaves hi/lo untouched.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             ready,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic             sq, sr, zflag;

  logic [WIDTH:0]   rem_sh, trial;
  logic             last_iter;

  // rem < |b| <= 2^(WIDTH-1), so the shifted value never reaches bit WIDTH and trial[WIDTH] is the borrow.
  assign rem_sh    = {rem[WIDTH-1:0], quo[WIDTH-1]};
  assign trial     = rem_sh - {1'b0, dvs};
  assign last_iter = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (b == '0) ? DONE : RUN;
      RUN:     if (last_iter) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      sq       <= 1'b0;
      sr       <= 1'b0;
      zflag    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      ready    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            zflag <= (b == '0);
            if (b != '0) begin
              quo <= a[WIDTH-1] ? -a : a;
              dvs <= b[WIDTH-1] ? -b : b;
              sq  <= a[WIDTH-1] ^ b[WIDTH-1];
              sr  <= a[WIDTH-1];
              rem <= '0;
              cnt <= '0;
            end
          end
        end
        RUN: begin
          quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
          rem <= trial[WIDTH] ? rem_sh : trial;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          lo <= sq ? -quo : quo;
          hi <= sr ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
        end
        default: ;
      endcase

      // Normal path: ready rises as FIX writes hi/lo. Zero path: ready rises one edge after acceptance.
      ready    <= (state == FIX) || ((state == DONE) && zflag);
      div_zero <= (state == DONE) && zflag;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed literal cases plus randomized traffic checked every cycle
// against a cycle-scheduled arithmetic model.
module tb_seq_divider;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a, b;
  logic [W-1:0] hi, lo;
  logic         ready, div_zero;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .hi(hi), .lo(lo), .ready(ready), .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: each accepted request schedules its result for a known edge number.
  int           cyc = 0;
  int           m_due = -1;
  int           m_free = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic [W-1:0] p_hi = '0, p_lo = '0;
  logic         p_dz = 1'b0;
  logic         exp_ready = 1'b0, exp_dz = 1'b0;

  task automatic model_reset();
    m_due = -1; m_free = 0;
    m_hi = '0; m_lo = '0;
    exp_ready = 1'b0; exp_dz = 1'b0;
  endtask

  initial begin
    longint q, r;
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset) begin
        exp_ready = 1'b0;
        exp_dz    = 1'b0;
        if (cyc == m_due) begin
          exp_ready = 1'b1;
          exp_dz    = p_dz;
          if (!p_dz) begin
            m_hi = p_hi;
            m_lo = p_lo;
          end
          m_due = -1;
        end
        if (start && cyc >= m_free) begin
          if (b == '0) begin
            p_dz   = 1'b1;
            m_due  = cyc + 1;
            m_free = cyc + 2;
          end else begin
            q      = longint'($signed(a)) / longint'($signed(b));
            r      = longint'($signed(a)) % longint'($signed(b));
            p_lo   = q[W-1:0];
            p_hi   = r[W-1:0];
            p_dz   = 1'b0;
            m_due  = cyc + W + 1;
            m_free = cyc + W + 3;
          end
        end
      end
      #1;
      check("cyc_ready", 32'(ready), 32'(exp_ready));
      check("cyc_div_zero", 32'(div_zero), 32'(exp_dz));
      check("cyc_hi", hi, m_hi);
      check("cyc_lo", lo, m_lo);
    end
  end

  task automatic run_op(input string nm, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input int inj, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input int exp_lat, input logic [W-1:0] exp_lo,
                        input logic [W-1:0] exp_hi, input logic exp_dzv);
    int nrdy, lat;
    logic [W-1:0] glo, ghi;
    logic gdz;
    nrdy = 0; lat = -1; glo = '0; ghi = '0; gdz = 1'b0;
    @(negedge clk);
    start = 1'b1; a = xa; b = xb;
    @(posedge clk);
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      start = (k == inj);
      if (k == inj) begin
        a = ia; b = ib;
      end else begin
        a = $urandom; b = $urandom;
      end
      @(posedge clk);
      #2;
      if (ready) begin
        nrdy++;
        if (nrdy == 1) begin
          lat = k; glo = lo; ghi = hi; gdz = div_zero;
        end
      end
    end
    check({nm, "_ready_count"}, 32'(nrdy), 32'd1);
    check({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    check({nm, "_lo"}, glo, exp_lo);
    check({nm, "_hi"}, ghi, exp_hi);
    check({nm, "_div_zero"}, 32'(gdz), 32'(exp_dzv));
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 6))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 20));
      3:       return 32'd0 - 32'($urandom_range(1, 20));
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nrdy;
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    model_reset();
    #1;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_div_zero", 32'(div_zero), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    run_op("u100_7", 32'd100, 32'd7, 0, '0, '0, 33, 32'd14, 32'd2, 1'b0);
    run_op("neg_a", 32'hFFFF_FFF9, 32'd2, 0, '0, '0, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_op("neg_b", 32'd7, 32'hFFFF_FFFE, 0, '0, '0, 33, 32'hFFFF_FFFD, 32'd1, 1'b0);
    run_op("neg_ab", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 0, '0, '0, 33, 32'd3, 32'hFFFF_FFFF, 1'b0);
    run_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 0, '0, '0, 33, 32'h8000_0000, 32'd0, 1'b0);
    run_op("load", 32'd100, 32'd7, 0, '0, '0, 33, 32'd14, 32'd2, 1'b0);
    run_op("zero", 32'd5, 32'd0, 0, '0, '0, 1, 32'd14, 32'd2, 1'b1);
    run_op("busy", 32'd100, 32'd7, 10, 32'd9, 32'd3, 33, 32'd14, 32'd2, 1'b0);

    // Asynchronous reset in the middle of a 1000/3 run.
    @(negedge clk);
    start = 1'b1; a = 32'd1000; b = 32'd3;
    @(posedge clk);
    repeat (14) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    check("midrst_ready", 32'(ready), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    nrdy = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #2;
      if (ready) nrdy++;
    end
    check("midrst_no_ready", 32'(nrdy), 32'd0);
    run_op("after_rst", 32'd1000, 32'd3, 0, '0, '0, 33, 32'd333, 32'd1, 1'b0);

    // Random traffic: starts land anywhere, including while busy.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 7) == 0);
      a = rnd_op();
      b = ($urandom_range(0, 9) == 0) ? '0 : rnd_op();
    end
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(posedge clk);
    #3;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential signed 32-bit divider serving as the responder on the CPU's `start`/`ready` divide handshake. The control unit pulses `start` with operands from registers A and B. The block computes a MIPS-style quotient and remainder with one bit per clock using restoring division. It then pulses `ready`, with the quotient on `lo` and the remainder on `hi` ready for loading into LO/HI. Division by zero is reported on `div_zero` so the control unit can raise the exception.

## Interface
- `WIDTH`, default 32: operand and result width in bits. The iteration count equals `WIDTH`.
- `clk` input 1: clock, rising-edge.
- `reset` input 1: asynchronous, active-high.
- `start` input 1: request pulse, sampled only in IDLE.
- `a` input WIDTH: dividend, two's complement, sampled with `start`.
- `b` input WIDTH: divisor, two's complement, sampled with `start`.
- `hi` output WIDTH: remainder, registered.
- `lo` output WIDTH: quotient, registered.
- `ready` output 1: one-cycle completion pulse, registered.
- `div_zero` output 1: one-cycle divide-by-zero pulse, coincident with `ready`.

## Operation
- States:
  - IDLE: wait for `start`.
  - RUN: perform the `WIDTH` iterations.
  - FIX: apply signs and write results.
  - DONE: pulse `ready`.
- IDLE with `start`=1 and `b`≠0:
  - Latch the dividend magnitude |a| into the quotient shift register.
  - Latch the divisor magnitude |b|.
  - Latch sign flags: sq = a[MSB]^b[MSB] and sr = a[MSB].
  - Clear the partial remainder (WIDTH+1 bits) and the counter.
  - Go to RUN.
- IDLE with `start`=1 and `b`=0:
  - Go to DONE with `div_zero` set.
  - `hi`/`lo` are not modified.
- Magnitudes are computed as unsigned WIDTH-bit values. |−2^(WIDTH−1)| = 2^(WIDTH−1) is representable unsigned.
- RUN, each cycle:
  - Shift {rem, quo} left by 1.
  - trial = rem − |b|.
  - If trial ≥ 0: rem ← trial and quo[0] ← 1. Otherwise restore, with quo[0] ← 0.
  - Increment the counter.
  - After iteration WIDTH, go to FIX.
- FIX:
  - `lo` ← sq ? −quo : quo.
  - `hi` ← sr ? −rem : rem.
  - All arithmetic truncates to WIDTH bits.
  - Go to DONE.
- Sign rules: the quotient truncates toward zero, and the remainder takes the sign of the dividend.
- Overflow case 0x80000000 / −1: `lo`=0x80000000 (wraps), `hi`=0. Not flagged.
- DONE:
  - `ready`=1 for exactly one cycle. `div_zero`=1 in the same cycle only on the zero-divisor path.
  - Go to IDLE unconditionally.
- `start` in RUN, FIX or DONE is ignored. Operand changes after acceptance have no effect.
- `hi`/`lo` hold their last written values indefinitely, including across later zero-divisor requests.
- Reset, asynchronous, at any time including mid-RUN:
  - State → IDLE.
  - `hi`, `lo`, `ready`, `div_zero`, counter and internal registers → 0.
  - An in-flight operation is discarded with no `ready` pulse.

## Timing
- Edge E0 samples `start` in IDLE.
- Normal path:
  - RUN iterations occur on edges E1..E_WIDTH.
  - FIX writes `hi`/`lo` on edge E_(WIDTH+1).
  - `ready` is high from E_(WIDTH+1) to E_(WIDTH+2). For WIDTH=32, that is 33 edges after `start`.
- Zero-divisor path: `ready`=`div_zero`=1 from E1 to E2, a latency of 1.
- `hi`/`lo` are valid in the same cycle `ready` is high and remain stable afterward.
- Earliest next acceptance: `start` sampled on the edge after DONE, i.e. IDLE at E_(WIDTH+2).
- All outputs come directly from flops. There is no combinational path from inputs to outputs.

## Test plan
- Unsigned-valued case: a=100, b=7, `start` pulse → exactly 33 edges later `ready`=1 for one cycle, `lo`=14, `hi`=2, `div_zero`=0.
- Sign combinations:
  - a=−7, b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - a=7, b=−2 → `lo`=0xFFFFFFFD, `hi`=1.
  - a=−7, b=−2 → `lo`=3, `hi`=0xFFFFFFFF.
- Zero divisor:
  1. Load `hi`=2, `lo`=14 via 100/7.
  2. Issue a=5, b=0 → one edge later `ready`=`div_zero`=1 for one cycle; `hi`=2 and `lo`=14 unchanged.
- Overflow: a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0, `div_zero`=0.
- Busy ignore:
  1. Start 100/7.
  2. Reassert `start` with a=9, b=3 at cycle 10 → single `ready` at 33 with `lo`=14, `hi`=2.
  3. No second `ready` follows.
- Reset mid-operation:
  1. Start 1000/3.
  2. Assert `reset` asynchronously at cycle 15 → `hi`=`lo`=0 and `ready`=0 immediately; no `ready` ever appears.
  3. After release, 1000/3 → `lo`=333, `hi`=1 at 33 edges.
